// File: rtl/startup_rom_wb_slave_if.sv
// Wishbone B3 bus bundle for the startup ROM responder; names are slave-relative
// so the slave modport reads like the original flat port list.
interface startup_rom_wb_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/startup_rom_wb_slave.sv
// Wishbone B3 read-only responder for the OR1K startup ROM: single reads and
// linear/wrap bursts at one beat per cycle, writes answered with err.
module startup_rom_wb_slave #(
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  startup_rom_wb_slave_if.slave wb,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [31:0]           rom_dout_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [2:0] CTI_INCR = 3'b010;

  logic [1:0]            state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cnt_next;
  logic [ADDR_WIDTH-1:0] adr_word;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  req;
  logic                  beat;
  logic                  unused_ok;

  assign req      = wb.wb_cyc_i & wb.wb_stb_i;
  assign beat     = ack_q & req;
  assign adr_word = wb.wb_adr_i[ADDR_WIDTH+1:2];

  // Data, byte selects and out-of-window address bits have no effect on a ROM.
  assign unused_ok = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

  always_comb begin
    cnt_next = cnt_q;
    case (wb.wb_bte_i)
      2'b00:   cnt_next = cnt_q + 1'b1;
      2'b01:   cnt_next[1:0] = cnt_q[1:0] + 2'd1;
      2'b10:   cnt_next[2:0] = cnt_q[2:0] + 3'd1;
      default: cnt_next[3:0] = cnt_q[3:0] + 4'd1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rom_addr = cnt_q;
    case (state_q)
      S_IDLE: begin
        rom_addr = adr_word;
        ack_d    = 1'b0;
        if (req) begin
          if (wb.wb_we_i) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            cnt_d   = adr_word;
            ack_d   = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (!wb.wb_cyc_i) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end else if (beat) begin
          // Presenting the next word now lets the ROM register it for the next beat.
          if (wb.wb_cti_i == CTI_INCR) begin
            rom_addr = cnt_next;
            cnt_d    = cnt_next;
          end else begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces the ROM address low even though IDLE otherwise passes the bus address through.
  assign rom_addr_o  = wb_rst_n ? rom_addr : '0;
  assign wb.wb_ack_o = beat;
  assign wb.wb_dat_o = beat ? rom_dout_i : '0;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_startup_rom_wb_slave.sv
// Scoreboarded bench for startup_rom_wb_slave: directed and random reads,
// bursts, wait states, writes and mid-burst reset against a word-level model.
module tb_startup_rom_wb_slave;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  logic        wb_clk;
  logic        wb_rst_n;
  logic [6:0]  rom_addr;
  logic [31:0] rom_q;
  exp_t        sb[$];
  int          pass_cnt;
  int          total_cnt;

  startup_rom_wb_slave_if wb();

  startup_rom_wb_slave #(.ADDR_WIDTH(7)) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .wb         (wb),
    .rom_addr_o (rom_addr),
    .rom_dout_i (rom_q)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // ROM with a registered address: data for the sampled word appears next cycle.
  always @(posedge wb_clk) rom_q <= 32'hC0DE0000 | {25'd0, rom_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Word sequence of a burst: bits inside the wrap window count up, bits above stay put.
  function automatic logic [31:0] exp_data(input int unsigned start, input int unsigned bte,
                                           input int unsigned i);
    int unsigned m, w;
    m = (bte == 0) ? 127 : ((1 << (bte + 1)) - 1);
    w = ((start & ~m) | ((start + i) & m)) & 127;
    return 32'hC0DE0000 | w;
  endfunction

  task automatic rd_burst(input logic [31:0] adr, input logic [1:0] bte, input int unsigned n,
                          input int unsigned gap_at, input int unsigned gap_len);
    int unsigned beats, cyc_cnt, start;
    logic        got;
    start = (adr >> 2) & 127;
    for (int unsigned k = 0; k < n; k++) sb.push_back('{1'b0, exp_data(start, 32'(bte), k)});
    wb.wb_adr_i = adr;
    wb.wb_we_i  = 1'b0;
    wb.wb_bte_i = bte;
    wb.wb_cti_i = (n == 1) ? 3'b000 : 3'b010;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    beats   = 0;
    cyc_cnt = 0;
    while (beats < n && cyc_cnt < 64) begin
      @(negedge wb_clk);
      cyc_cnt++;
      got = wb.wb_ack_o;
      if (got) begin
        if (beats == 0) check("first_ack_latency", cyc_cnt, 32'd2);
        beats++;
      end
      @(posedge wb_clk);
      #1;
      if (beats == n) begin
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_cti_i = 3'b000;
      end else begin
        if (beats == n - 1) wb.wb_cti_i = 3'b111;
        if (got && gap_len != 0 && beats == gap_at) begin
          wb.wb_stb_i = 1'b0;
          repeat (gap_len) @(posedge wb_clk);
          #1;
          wb.wb_stb_i = 1'b1;
        end
      end
    end
    if (beats < n) begin
      check("burst_timeout", beats, n);
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      sb.delete();
      @(posedge wb_clk);
      #1;
    end
  endtask

  task automatic wr_single(input logic [31:0] adr);
    int unsigned cyc_cnt;
    logic        seen;
    sb.push_back('{1'b1, 32'd0});
    wb.wb_adr_i = adr;
    wb.wb_dat_i = $urandom;
    wb.wb_we_i  = 1'b1;
    wb.wb_cti_i = 3'b000;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    cyc_cnt = 0;
    seen    = 1'b0;
    while (!seen && cyc_cnt < 8) begin
      @(negedge wb_clk);
      cyc_cnt++;
      seen = wb.wb_err_o;
    end
    check("err_latency", cyc_cnt, 32'd2);
    if (!seen) sb.delete();
    @(posedge wb_clk);
    #1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk);
      if (wb_rst_n) begin
        if (wb.wb_ack_o || wb.wb_err_o) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", {30'd0, wb.wb_err_o, wb.wb_ack_o}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("resp_kind", {30'd0, wb.wb_err_o, wb.wb_ack_o}, e.is_err ? 32'd2 : 32'd1);
            if (!e.is_err) check("rd_data", wb.wb_dat_o, e.data);
          end
        end else begin
          check("dat_zero_no_ack", wb.wb_dat_o, 32'd0);
        end
      end
    end
  end

  initial begin
    int unsigned got, cnt;
    pass_cnt      = 0;
    total_cnt     = 0;
    wb_rst_n      = 1'b0;
    wb.wb_adr_i   = 32'h7C;
    wb.wb_dat_i   = '0;
    wb.wb_sel_i   = 4'hF;
    wb.wb_we_i    = 1'b0;
    wb.wb_cyc_i   = 1'b1;
    wb.wb_stb_i   = 1'b1;
    wb.wb_cti_i   = 3'b000;
    wb.wb_bte_i   = 2'b00;
    repeat (3) @(negedge wb_clk);
    check("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rst_err", {31'd0, wb.wb_err_o}, 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb_rst_n    = 1'b1;
    @(posedge wb_clk);
    #1;

    rd_burst(32'h14, 2'b00, 1, 0, 0);
    rd_burst(32'h18, 2'b00, 1, 0, 0);
    rd_burst(32'h1F8, 2'b00, 4, 0, 0);
    rd_burst(32'h38, 2'b01, 4, 0, 0);
    rd_burst(32'h38, 2'b10, 8, 0, 0);
    rd_burst(32'h2C, 2'b11, 16, 0, 0);
    rd_burst(32'h40, 2'b00, 4, 2, 2);
    wr_single(32'h0);
    rd_burst(32'h4, 2'b00, 1, 0, 0);

    // Mid-burst asynchronous reset.
    for (int unsigned k = 0; k < 8; k++) sb.push_back('{1'b0, exp_data(32'h7C, 0, k)});
    wb.wb_adr_i = 32'h1F0;
    wb.wb_we_i  = 1'b0;
    wb.wb_bte_i = 2'b00;
    wb.wb_cti_i = 3'b010;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    got = 0;
    cnt = 0;
    while (got < 2 && cnt < 20) begin
      @(negedge wb_clk);
      cnt++;
      if (wb.wb_ack_o) got++;
    end
    check("rst_burst_started", got, 32'd2);
    @(posedge wb_clk);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("midrst_err", {31'd0, wb.wb_err_o}, 32'd0);
    check("midrst_dat", wb.wb_dat_o, 32'd0);
    check("midrst_rom_addr", {25'd0, rom_addr}, 32'd0);
    sb.delete();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_cti_i = 3'b000;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(posedge wb_clk);
    #1;
    rd_burst(32'h0, 2'b00, 1, 0, 0);

    for (int unsigned t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        wr_single($urandom);
      end else begin
        int unsigned n;
        n = $urandom_range(1, 12);
        rd_burst($urandom, 2'($urandom_range(0, 3)), n,
                 $urandom_range(1, 12), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
      repeat ($urandom_range(0, 2)) @(posedge wb_clk);
      #1;
    end

    repeat (4) @(posedge wb_clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/startup_rom_wb_slave.md
Name: startup_rom_wb_slave

Overview:
Wishbone B3 responder that puts the OR1K startup ROM on the instruction/data bus. It converts CPU read cycles into word addresses for the ROM's registered-address read port and returns the ROM data with ack. It supports classic single reads and incrementing bursts (linear and wrap-4/8/16) at one beat per cycle. Writes are refused with err.

Parameters:
ADDR_WIDTH, 7, ROM word-address width; the ROM holds 2^ADDR_WIDTH 32-bit words.

Ports:
wb_clk  in  1  system clock, all logic on rising edge
wb_rst_n  in  1  reset, asynchronous, active-low
wb_adr_i  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word, other bits ignored
wb_dat_i  in  32  write data, ignored
wb_sel_i  in  4  byte selects, ignored (full word always returned)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wb_dat_o  out  32  read data; rom_dout_i when wb_ack_o=1, else 0
wb_ack_o  out  1  read beat acknowledge
wb_err_o  out  1  error response to writes
wb_rty_o  out  1  tied 0
rom_addr_o  out  ADDR_WIDTH  ROM word address; the ROM registers it on wb_clk, and data is valid on rom_dout_i the following cycle
rom_dout_i  in  32  ROM data

Behaviour:
- Reset (wb_rst_n=0, asynchronous):
  - state IDLE, ack_reg 0, err 0, word counter 0.
  - Outputs: wb_ack_o 0, wb_err_o 0, wb_dat_o 0, rom_addr_o 0.
  - Reset asserted mid-cycle aborts the access immediately; no late ack.
- req = wb_cyc_i & wb_stb_i. Outputs: wb_ack_o = ack_reg & req; wb_dat_o = wb_ack_o ? rom_dout_i : 0.
- States: IDLE, READ, ERR.
- IDLE:
  - rom_addr_o = wb_adr_i[ADDR_WIDTH+1:2] (combinational).
  - On req & !wb_we_i: counter <= that word, ack_reg <= 1, go READ. Data is acked in the next cycle, so latency is 1 wait cycle.
  - On req & wb_we_i: err <= 1, go ERR. The ROM is not addressed for the write.
- READ, beat accepted (wb_ack_o=1):
  - If wb_cti_i=010: rom_addr_o = next(counter) combinationally, counter <= next(counter), ack_reg stays 1. Result is back-to-back beats, one per cycle.
  - Else (000, 111, or any other value): ack_reg <= 0, go IDLE. A new request is accepted in the cycle after the ack, so a classic read takes 2 cycles.
- READ, no beat (req=0 with wb_cyc_i=1, i.e. a master wait state):
  - rom_addr_o = counter (held), ack_reg stays 1.
  - No address advance. The same word is re-presented when stb returns: no skip, no duplicate.
- READ, wb_cyc_i=0: ack_reg <= 0, go IDLE (burst aborted).
- ERR: wb_err_o high for exactly one cycle, then IDLE. ack never asserts for a write.
- next(c) by wb_bte_i, sampled at each accepted beat:
  - 00: c+1 mod 2^ADDR_WIDTH (wraps from top to word 0).
  - 01: low 2 bits increment with wrap, upper bits held.
  - 10: low 3 bits wrap.
  - 11: low 4 bits wrap.
- Any address above the ROM size aliases by truncation; no error is raised.
- Only one access is outstanding; nothing is buffered beyond the ROM's address register.

Test Plan:
Bench ROM model returns 32'hC0DE0000 | word_index, one-cycle registered read.
- Reset: assert wb_rst_n=0 in the middle of a linear burst -> wb_ack_o, wb_err_o and wb_dat_o are 0 and rom_addr_o is 0 in the same cycle. After release, the next single read at 0x0 returns 0xC0DE0000.
- Single read: adr 0x14, cti 000 -> ack for exactly 1 cycle, one cycle after request, with data 0xC0DE0005. A follow-up read at 0x18 issued right after the ack -> ack 2 cycles later with 0xC0DE0006.
- Linear burst with wrap-around: adr 0x1F8, cti 010, bte 00, 4 beats, last beat cti 111 -> acks on 4 consecutive cycles with data ...7E, ...7F, ...00, ...01. Ack low the following cycle.
- Wrap4 burst: adr 0x38, bte 01, 4 beats -> words 0x0E, 0x0F, 0x0C, 0x0D. A wrap8 burst from word 0x0E returns 0x0E, 0x0F, 0x08 ... 0x0D.
- Wait states: burst from 0x40 with stb low for 2 cycles after beat 2 -> no ack during the gap; beat 3 = 0xC0DE0012, beat 4 = 0xC0DE0013.
- Write: cyc/stb/we at 0x0 -> wb_err_o high for 1 cycle, wb_ack_o never asserts. A following read at 0x4 returns 0xC0DE0001 normally.
